// File: rtl/console_tx_pkg.sv
// Shared types for the console transmitter: FSM states, parity modes and the parity helper.
package console_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } uart_parity_t;

    // Characters narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input uart_parity_t mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// Synchronous FIFO buffering characters between the CPU write port and the serialiser.
module tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally; count carries the extra bit that tells full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/console_tx.sv
// FIFO-buffered serial console transmitter: frames queued characters as start, data LSB-first,
// optional parity and stop bits at a fixed bit period, back-to-back while the FIFO has data.
module console_tx
    import console_tx_pkg::*;
#(
    parameter int DATA_BITS    = 7,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        wr_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow
);

    localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam uart_parity_t PAR_CFG = (PARITY_MODE == 1) ? PAR_EVEN :
                                       (PARITY_MODE == 2) ? PAR_ODD  : PAR_NONE;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("console_tx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("console_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("console_tx: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_MODE < 0) || (PARITY_MODE > 2)) begin : g_bad_parity
        $error("console_tx: PARITY_MODE must be 0, 1 or 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data
        $error("console_tx: DATA_BITS must be in 5..8");
    end

    uart_state_t          state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign wr_ready  = !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign busy      = (state != TX_IDLE) || (level != '0);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // A new character is taken either from idle or on the last stop cycle, so frames abut.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            fifo_pop = (state == TX_IDLE) || ((state == TX_STOP) && (clk_cnt == STOP_LAST));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= wr_valid && !wr_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= TX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
        end else if (fifo_pop) begin
            shift      <= fifo_data;
            parity_bit <= calc_parity(8'(fifo_data), PAR_CFG);
            clk_cnt    <= '0;
            txd        <= 1'b0;
            state      <= TX_START;
        end else begin
            case (state)
                TX_IDLE: begin
                    txd <= 1'b1;
                end
                TX_START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        shift   <= shift >> 1;
                        state   <= TX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            if (PAR_CFG != PAR_NONE) begin
                                txd   <= parity_bit;
                                state <= TX_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= TX_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        txd     <= 1'b1;
                        state   <= TX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (clk_cnt == STOP_LAST) begin
                        clk_cnt <= '0;
                        state   <= TX_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
